// File: rtl/ysyx_24100005_mux_key_reg.sv
// Register with synchronous reset and write enable, plus an independent
// combinational key/data lookup table with a default value.
module ysyx_24100005_mux_key_reg #(
    parameter int              WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int              NR_KEY    = 2,
    parameter int              KEY_LEN   = 1,
    parameter int              DATA_LEN  = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [WIDTH-1:0]                   din,
    input  logic                               wen,
    output logic [WIDTH-1:0]                   dout,
    input  logic [KEY_LEN-1:0]                 key,
    input  logic [DATA_LEN-1:0]                default_out,
    input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut,
    output logic [DATA_LEN-1:0]                out
);

    localparam int P = KEY_LEN + DATA_LEN;

    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= RESET_VAL;
        end else if (wen) begin
            dout <= din;
        end
    end

    logic [NR_KEY-1:0]   hit;
    logic [DATA_LEN-1:0] pair_data [NR_KEY];

    for (genvar i = 0; i < NR_KEY; i++) begin : g_pair
        assign hit[i]       = (lut[i*P+DATA_LEN +: KEY_LEN] == key);
        assign pair_data[i] = lut[i*P +: DATA_LEN];
    end

    // Walk from the top down so the lowest-indexed match is written last.
    always_comb begin
        out = default_out;
        for (int i = NR_KEY - 1; i >= 0; i--) begin
            if (hit[i]) begin
                out = pair_data[i];
            end
        end
    end

endmodule

// File: tb/tb_ysyx_24100005_mux_key_reg.sv
// Self-checking bench: directed scenarios plus randomized register and
// lookup traffic against a behavioural model.
module tb_ysyx_24100005_mux_key_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        wen;
    logic [31:0] din;

    logic [31:0] dout_a, dout_s4, dout_s5;
    logic [2:0]  key_a;
    logic [4:0]  dflt_a;
    logic [31:0] lut_a;
    logic [4:0]  out_a;

    logic [6:0]  key_s4;
    logic        dflt_s4;
    logic [7:0]  lut_s4;
    logic        out_s4;

    logic [1:0]  key_s5;
    logic [3:0]  dflt_s5;
    logic [11:0] lut_s5;
    logic [3:0]  out_s5;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] exp_dout;
    logic [2:0]  keys_q [4];
    logic [4:0]  data_q [4];

    always #5 clk = ~clk;

    ysyx_24100005_mux_key_reg #(
        .WIDTH(32), .RESET_VAL(32'h8000_0000),
        .NR_KEY(4), .KEY_LEN(3), .DATA_LEN(5)
    ) u_a (
        .clk(clk), .rst(rst), .din(din), .wen(wen), .dout(dout_a),
        .key(key_a), .default_out(dflt_a), .lut(lut_a), .out(out_a)
    );

    ysyx_24100005_mux_key_reg #(
        .NR_KEY(1), .KEY_LEN(7), .DATA_LEN(1)
    ) u_s4 (
        .clk(clk), .rst(rst), .din(din), .wen(wen), .dout(dout_s4),
        .key(key_s4), .default_out(dflt_s4), .lut(lut_s4), .out(out_s4)
    );

    ysyx_24100005_mux_key_reg #(
        .NR_KEY(2), .KEY_LEN(2), .DATA_LEN(4)
    ) u_s5 (
        .clk(clk), .rst(rst), .din(din), .wen(wen), .dout(dout_s5),
        .key(key_s5), .default_out(dflt_s5), .lut(lut_s5), .out(out_s5)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] ref_lookup(input logic [2:0] k, input logic [4:0] d);
        for (int i = 0; i < 4; i++) begin
            if (keys_q[i] === k) return data_q[i];
        end
        return d;
    endfunction

    task automatic pack_lut_a();
        lut_a = '0;
        for (int i = 0; i < 4; i++) lut_a[i*8 +: 8] = {keys_q[i], data_q[i]};
    endtask

    task automatic test_reset();
        rst = 1'b1; wen = 1'b0; din = 32'h0;
        tick();
        vectors++;
        if (dout_a !== 32'h8000_0000) begin
            miscompares++;
            $display("FAIL reset_val dout=%h expected=%h", dout_a, 32'h8000_0000);
        end
        vectors++;
        if (dout_s4 !== 32'h0 || dout_s5 !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_default dout_s4=%h dout_s5=%h expected=0", dout_s4, dout_s5);
        end
        exp_dout = 32'h8000_0000;
    endtask

    task automatic test_write_hold();
        rst = 1'b0; wen = 1'b1; din = 32'h8000_0004;
        tick();
        vectors++;
        if (dout_a !== 32'h8000_0004) begin
            miscompares++;
            $display("FAIL write dout=%h expected=%h", dout_a, 32'h8000_0004);
        end
        wen = 1'b0; din = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (dout_a !== 32'h8000_0004) begin
                miscompares++;
                $display("FAIL hold%0d dout=%h expected=%h", i, dout_a, 32'h8000_0004);
            end
        end
    endtask

    task automatic test_reset_priority();
        rst = 1'b1; wen = 1'b1; din = 32'h1234_5678;
        tick();
        vectors++;
        if (dout_a !== 32'h8000_0000) begin
            miscompares++;
            $display("FAIL rst_over_wen dout=%h expected=%h", dout_a, 32'h8000_0000);
        end
        rst = 1'b0; wen = 1'b0;
        exp_dout = 32'h8000_0000;
    endtask

    task automatic test_lookup_s4();
        logic [6:0] ks [3];
        logic       ex [3];
        ks[0] = 7'h03; ks[1] = 7'h13; ks[2] = 7'h23;
        ex[0] = 1'b1;  ex[1] = 1'b0;  ex[2] = 1'b0;
        lut_s4 = {7'b000_0011, 1'b1};
        dflt_s4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            key_s4 = ks[i];
            #1;
            vectors++;
            if (out_s4 !== ex[i]) begin
                miscompares++;
                $display("FAIL s4_key%h out=%b expected=%b", ks[i], out_s4, ex[i]);
            end
        end
    endtask

    task automatic test_lookup_s5();
        lut_s5 = {2'b01, 4'hA, 2'b01, 4'h5};
        dflt_s5 = 4'hF;
        key_s5 = 2'b01;
        #1;
        vectors++;
        if (out_s5 !== 4'h5) begin
            miscompares++;
            $display("FAIL s5_dup out=%h expected=%h", out_s5, 4'h5);
        end
        key_s5 = 2'b10;
        #1;
        vectors++;
        if (out_s5 !== 4'hF) begin
            miscompares++;
            $display("FAIL s5_miss out=%h expected=%h", out_s5, 4'hF);
        end
    endtask

    task automatic test_lookup_random();
        logic [4:0] exp;
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 4; i++) begin
                keys_q[i] = 3'($urandom_range(0, 7));
                data_q[i] = 5'($urandom_range(0, 31));
            end
            pack_lut_a();
            dflt_a = 5'($urandom_range(0, 31));
            key_a = 3'($urandom_range(0, 7));
            #1;
            exp = ref_lookup(key_a, dflt_a);
            vectors++;
            if (out_a !== exp) begin
                miscompares++;
                $display("FAIL lut_rand n=%0d key=%h out=%h expected=%h", n, key_a, out_a, exp);
            end
        end
    endtask

    task automatic test_reg_random();
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 15) == 0);
            wen = 1'($urandom_range(0, 1));
            din = $urandom();
            tick();
            if (rst) exp_dout = 32'h8000_0000;
            else if (wen) exp_dout = din;
            vectors++;
            if (dout_a !== exp_dout) begin
                miscompares++;
                $display("FAIL reg_rand n=%0d rst=%b wen=%b dout=%h expected=%h",
                         n, rst, wen, dout_a, exp_dout);
            end
        end
        rst = 1'b0; wen = 1'b0;
    endtask

    task automatic test_reset_no_out();
        logic [4:0] exp;
        keys_q[0] = 3'd1; keys_q[1] = 3'd5; keys_q[2] = 3'd5; keys_q[3] = 3'd2;
        data_q[0] = 5'd7; data_q[1] = 5'd19; data_q[2] = 5'd3; data_q[3] = 5'd30;
        pack_lut_a();
        dflt_a = 5'd12;
        key_a = 3'd5;
        exp = ref_lookup(key_a, dflt_a);
        wen = 1'b0;
        for (int n = 0; n < 8; n++) begin
            rst = n[0];
            tick();
            if (rst) exp_dout = 32'h8000_0000;
            vectors++;
            if (out_a !== exp || dout_a !== exp_dout) begin
                miscompares++;
                $display("FAIL rst_toggle n=%0d out=%h expected=%h dout=%h expected=%h",
                         n, out_a, exp, dout_a, exp_dout);
            end
            @(negedge clk);
            #1;
            vectors++;
            if (out_a !== exp) begin
                miscompares++;
                $display("FAIL rst_toggle_neg n=%0d out=%h expected=%h", n, out_a, exp);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0; wen = 1'b0; din = '0;
        key_a = '0; dflt_a = '0; lut_a = '0;
        key_s4 = '0; dflt_s4 = '0; lut_s4 = '0;
        key_s5 = '0; dflt_s5 = '0; lut_s5 = '0;
        exp_dout = '0;
        #2;
        test_reset();
        test_write_hold();
        test_reset_priority();
        test_lookup_s4();
        test_lookup_s5();
        test_lookup_random();
        test_reg_random();
        test_reset_no_out();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ysyx_24100005_mux_key_reg.md
YSYX_24100005_MUX_KEY_REG -- requirements
Module: ysyx_24100005_mux_key_reg

Interface
REQ-001 The block SHALL use a single clock and a synchronous, active-high reset; the clock port is clk and the reset port is rst.
REQ-002 Parameter WIDTH, default 32: bit width of the register datapath.
REQ-003 Parameter RESET_VAL, default 32'h0000_0000: register value loaded on reset; it is WIDTH bits wide.
REQ-004 Parameter NR_KEY, default 2: number of key/data pairs in the lookup table (at least 1).
REQ-005 Parameter KEY_LEN, default 1: key width in bits.
REQ-006 Parameter DATA_LEN, default 1: data width in bits.
REQ-007 clk  input  1  rising-edge clock for the register section.
REQ-008 rst  input  1  synchronous active-high reset for the register section.
REQ-009 din  input  WIDTH  register write data.
REQ-010 wen  input  1  register write enable.
REQ-011 dout  output  WIDTH  register contents.
REQ-012 key  input  KEY_LEN  lookup key.
REQ-013 default_out  input  DATA_LEN  value driven when no table key matches.
REQ-014 lut  input  NR_KEY*(KEY_LEN+DATA_LEN)  packed table of key/data pairs.
REQ-015 out  output  DATA_LEN  lookup result.

Function -- register section
REQ-016 On a rising clk edge with rst=1, dout SHALL become RESET_VAL, regardless of wen and din.
REQ-017 On a rising clk edge with rst=0 and wen=1, dout SHALL become din.
REQ-018 On a rising clk edge with rst=0 and wen=0, dout SHALL hold its value.
REQ-019 dout SHALL change only on rising clk edges; there is no asynchronous path from rst, din or wen to dout.
REQ-020 When rst and wen are asserted in the same cycle, reset SHALL win.
REQ-021 The register SHALL have no wrap or arithmetic; it is a pure WIDTH-bit storage element.

Function -- lookup section
REQ-022 Pair i (0..NR_KEY-1) SHALL occupy lut[(i+1)*P-1 : i*P], where P = KEY_LEN+DATA_LEN; pair 0 is in the least-significant bits.
REQ-023 Within each pair, the key SHALL be the upper KEY_LEN bits and the data SHALL be the lower DATA_LEN bits.
REQ-024 out SHALL be purely combinational in key, default_out and lut, and SHALL be independent of clk and rst.
REQ-025 If exactly one pair key equals key, out SHALL equal that pair's data.
REQ-026 If several pair keys equal key, out SHALL equal the data of the lowest-indexed matching pair.
REQ-027 If no pair key equals key, out SHALL equal default_out.
REQ-028 The comparison SHALL be an exact bitwise equality over all KEY_LEN bits, with no wildcards.
REQ-029 out SHALL contain no latches and SHALL be fully defined for every input combination.

Reset
REQ-030 After the first rising edge with rst=1, dout SHALL equal RESET_VAL.
REQ-031 Before the first reset edge, dout is undefined; the bench SHALL NOT check dout then.
REQ-032 Reset SHALL NOT affect out.
REQ-033 Reset asserted mid-operation SHALL load RESET_VAL on the next rising edge, discarding any concurrent write.

Verification
REQ-034 Scenario 1: WIDTH=32, RESET_VAL=32'h8000_0000, rst=1 for one edge -> dout=32'h8000_0000.
REQ-035 Scenario 2: rst=0, wen=1, din=32'h8000_0004, one edge -> dout=32'h8000_0004; then wen=0, din=32'hDEAD_BEEF, two edges -> dout stays 32'h8000_0004.
REQ-036 Scenario 3: rst=1, wen=1, din=32'h1234_5678, one edge -> dout=32'h8000_0000.
REQ-037 Scenario 4: NR_KEY=1, KEY_LEN=7, DATA_LEN=1, lut={7'b000_0011,1'b1}, default_out=0; key=7'h03 -> out=1; key=7'h13 -> out=0; key=7'h23 -> out=0.
REQ-038 Scenario 5: NR_KEY=2, KEY_LEN=2, DATA_LEN=4, lut={2'b01,4'hA,2'b01,4'h5}, default_out=4'hF; key=2'b01 -> out=4'h5 (pair 0 wins); key=2'b10 -> out=4'hF.
REQ-039 Scenario 6: toggle clk and rst while key, lut and default_out are held constant -> out unchanged at all times.
